wide_fifo_ctrl: RTL
===================

WIDE_FIFO_CTRL -- requirements
Module: wide_fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, word-address width; DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter WR_RATIO, default 2, words stored per write; power of two, 1..DEPTH.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 Ports, in order:
 clk  input  1  rising-edge clock.
 reset_n  input  1  synchronous, active-low reset.
 wr  input  1  write request (WR_RATIO words).
 rd  input  1  read request (one word).
 w_addr  output  ADDR_WIDTH  base word address of the current write.
 r_addr  output  ADDR_WIDTH  word address of the current read.
 full  output  1  fewer than WR_RATIO free words.
 empty  output  1  zero stored words.
 almost_full  output  1  count >= AF_LEVEL.
 almost_empty  output  1  count <= AE_LEVEL.
 count  output  ADDR_WIDTH+1  stored words, 0..DEPTH.
 wr_ack  output  1  write accepted this cycle (combinational).
 rd_ack  output  1  read accepted this cycle (combinational).

Function
REQ-006 Write accepted iff wr=1 and full=0; read accepted iff rd=1 and empty=0; decisions independent, both from registered state.
REQ-007 Accepted write: w_addr advances by WR_RATIO mod DEPTH at next edge; external storage writes words w_addr..w_addr+WR_RATIO-1.
REQ-008 Accepted read: r_addr advances by 1 mod DEPTH at next edge; storage word at r_addr is the read data this cycle.
REQ-009 w_addr always a multiple of WR_RATIO; a write never wraps mid-burst.
REQ-010 count_next = count + WR_RATIO*wr_ack - rd_ack, computed at ADDR_WIDTH+2 bits, never outside 0..DEPTH.
REQ-011 full, empty, almost_full, almost_empty registered and derived from count_next; one-cycle latency from request to flag update.
REQ-012 wr and rd together while empty: write accepted, read rejected; next cycle empty=0, count=WR_RATIO.
REQ-013 wr and rd together while full: read accepted, write rejected; full deasserts next cycle only if free words reach WR_RATIO.
REQ-014 wr and rd together otherwise: both accepted; count changes by WR_RATIO-1.
REQ-015 Rejected requests change no state; wr_ack/rd_ack stay 0.
REQ-016 Pointers wrap silently; full/empty come from count, never from pointer comparison.

Reset
REQ-017 reset_n=0 at a rising edge forces w_addr=0, r_addr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-018 Reset mid-operation discards all contents; requests during reset are not acknowledged.

Configuration
REQ-019 With FIFO_CTRL_ERR_FLAGS_EN defined: outputs overflow and underflow (1 bit each), sticky, set the cycle after a rejected wr/rd, cleared only by reset.
REQ-020 Without FIFO_CTRL_ERR_FLAGS_EN: those ports and their logic are absent; all other behaviour identical.

Structure
REQ-021 Package fifo_ctrl_pkg holds the status struct typedef (full, empty, almost_full, almost_empty) and the function computing free words from count.
REQ-022 Sub-module fifo_ptr (parametrised width and step, enable, wraps mod 2**width) is instantiated for the write and read pointers.

Verification (ADDR_WIDTH=3, WR_RATIO=2, AF_LEVEL=6, AE_LEVEL=2)
REQ-023 Reset then 4 writes -> w_addr 0,2,4,6 then 0; count 8; full=1 after 3rd write (count 6, free 2 >= 2? no: full only at count 8, i.e. after 4th); 5th wr gives wr_ack=0.
REQ-024 From full, 8 reads -> r_addr 0..7 then 0; empty=1 after 8th; 9th rd gives rd_ack=0.
REQ-025 Empty, wr=rd=1 one cycle -> wr_ack=1, rd_ack=0; next cycle count=2, empty=0, almost_empty=1.
REQ-026 count=4, wr=rd=1 two cycles -> count 5 then 6; almost_full=1 at 6; full=0.
REQ-027 count=7 (free 1), wr=1 -> wr_ack=0, full=1; one rd -> count 6, full=0 next cycle.
REQ-028 Reset asserted at count=5 -> next cycle count=0, empty=1, w_addr=r_addr=0; with FIFO_CTRL_ERR_FLAGS_EN, overflow cleared.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the wide-write FIFO controller.
//
// Contents:
//   fifo_status_t - registered status flags (full, empty, almost_full, almost_empty)
//   StatusReset   - flag values forced by reset (empty, nothing else asserted)
//   free_words()  - number of unoccupied words for a given occupancy
//   calc_status() - derives all four flags from an occupancy value
package fifo_ctrl_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    localparam fifo_status_t StatusReset = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Saturates at zero so an out-of-range occupancy can never report spare room.
    function automatic int unsigned free_words(input int unsigned count,
                                               input int unsigned depth);
        return (count >= depth) ? 0 : depth - count;
    endfunction

    // "full" means a whole write burst no longer fits, not that every word is used.
    function automatic fifo_status_t calc_status(input int unsigned count,
                                                 input int unsigned depth,
                                                 input int unsigned wr_ratio,
                                                 input int unsigned af_level,
                                                 input int unsigned ae_level);
        fifo_status_t st;
        st.full         = free_words(count, depth) < wr_ratio;
        st.empty        = (count == 0);
        st.almost_full  = (count >= af_level);
        st.almost_empty = (count <= ae_level);
        return st;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer.
//
// Advances by STEP on every enabled clock edge, modulo 2**WIDTH. Reset is
// synchronous and active-low, returning the pointer to zero.
//
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - synchronous active-low reset
//   en_i   - advance the pointer at the next edge
//   ptr_o  - current pointer value
module fifo_ptr #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Truncating STEP to WIDTH bits gives the modulo wrap for free; a step equal
    // to the full range becomes zero, which is the correct wrapped result.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/wide_fifo_ctrl.sv
// Wide-write / narrow-read FIFO controller.
//
// Each accepted write stores WR_RATIO consecutive words starting at w_addr;
// each accepted read consumes one word at r_addr. The storage array itself is
// external: this block only produces addresses, acknowledges and status.
// Occupancy is tracked in words; all flags come from that count, never from
// comparing pointers.
//
// Ports:
//   clk          - rising-edge clock
//   reset_n      - synchronous active-low reset
//   wr           - write request (WR_RATIO words)
//   rd           - read request (one word)
//   w_addr       - base word address of the current write
//   r_addr       - word address of the current read
//   full         - fewer than WR_RATIO free words
//   empty        - no stored words
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - stored words, 0..DEPTH
//   wr_ack       - write accepted this cycle (combinational)
//   rd_ack       - read accepted this cycle (combinational)
//   overflow     - sticky: a write was rejected (only with FIFO_CTRL_ERR_FLAGS_EN)
//   underflow    - sticky: a read was rejected (only with FIFO_CTRL_ERR_FLAGS_EN)
//
// Build option: define FIFO_CTRL_ERR_FLAGS_EN to add the overflow/underflow ports.
module wide_fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned WR_RATIO   = 2,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_ack,
    output logic                  rd_ack
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // One spare bit above the count width so the intermediate sum cannot alias.
    localparam int unsigned CW    = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH:0] count_q, count_d;
    logic [CW-1:0]       count_ext;
    fifo_status_t        status_q, status_d;
    logic                wr_ok, rd_ok;

    // Accept decisions use only registered flags, so wr and rd never interact
    // within a cycle. Gating with reset_n keeps requests made during reset
    // unacknowledged even before the flags have been reset.
    assign wr_ok = wr & ~status_q.full  & reset_n;
    assign rd_ok = rd & ~status_q.empty & reset_n;

    assign wr_ack = wr_ok;
    assign rd_ack = rd_ok;

    always_comb begin
        count_ext = {1'b0, count_q};
        if (wr_ok) begin
            count_ext = count_ext + CW'(WR_RATIO);
        end
        if (rd_ok) begin
            count_ext = count_ext - CW'(1);
        end
        count_d  = count_ext[ADDR_WIDTH:0];
        status_d = calc_status(32'(count_ext), DEPTH, WR_RATIO, AF_LEVEL, AE_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            status_q <= StatusReset;
        end else begin
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;

    // Write pointer steps by a whole burst, so it stays burst-aligned and a
    // burst never straddles the wrap point.
    fifo_ptr #(
        .WIDTH (ADDR_WIDTH),
        .STEP  (WR_RATIO)
    ) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (wr_ok),
        .ptr_o  (w_addr)
    );

    fifo_ptr #(
        .WIDTH (ADDR_WIDTH),
        .STEP  (1)
    ) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (rd_ok),
        .ptr_o  (r_addr)
    );

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky until reset; a rejected request is one seen while the blocking
    // flag is set (reset_n low clears regardless, via the register below).
    always_comb begin
        overflow_d  = overflow_q  | (wr & status_q.full);
        underflow_d = underflow_q | (rd & status_q.empty);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
